// File: rtl/mips_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mips_cpu_bus_arbiter
// Description : Arbitrates a MIPS core's instruction-fetch (I) and data (D)
//               Avalon-style ports onto one shared memory bus. Round-robin
//               on contention, one access in flight, a wait-cycle timeout,
//               and sticky protocol-error / timeout status flags.
// Revision    : 1.0 - initial release
// ============================================================================
module mips_cpu_bus_arbiter #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        reset,

  // Instruction-fetch port (read only)
  input  logic        i_read,
  input  logic [31:0] i_addr,
  output logic        i_waitrequest,
  output logic        i_readdatavalid,
  output logic [31:0] i_readdata,

  // Data port
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic        d_readdatavalid,
  output logic [31:0] d_readdata,

  // Shared memory bus
  output logic        m_read,
  output logic        m_write,
  output logic [31:0] m_addr,
  output logic [31:0] m_writedata,
  output logic [3:0]  m_byteenable,
  input  logic        m_waitrequest,
  input  logic [31:0] m_readdata,

  // Sticky status
  output logic        protocol_error,
  output logic        timeout
);

  // The counter only has to hold 0 .. MAX_WAIT-1: the abort fires on the
  // stalled cycle that would bring it to MAX_WAIT.
  localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(MAX_WAIT - 1);

  // Grant encoding: 0 = instruction port, 1 = data port.
  localparam logic C_GRANT_I = 1'b0;
  localparam logic C_GRANT_D = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BUSY  = 2'd1,
    S_RDATA = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             protocol_error_q, protocol_error_d;
  logic             timeout_q, timeout_d;

  logic        w_i_req;
  logic        w_d_req;
  logic        w_g_read;
  logic        w_g_write;
  logic [31:0] w_g_addr;

  // Requests and the view of the currently granted port. A D-port request
  // with both read and write set is served as a read; the write is dropped.
  always_comb begin
    w_i_req   = i_read;
    w_d_req   = d_read | d_write;
    w_g_read  = (grant_q == C_GRANT_D) ? d_read : i_read;
    w_g_write = (grant_q == C_GRANT_D) ? (d_write & ~d_read) : 1'b0;
    w_g_addr  = (grant_q == C_GRANT_D) ? d_addr : i_addr;
  end

  // Next-state, arbitration, bus muxing and status-flag logic.
  always_comb begin
    state_d          = state_q;
    grant_d          = grant_q;
    last_grant_d     = last_grant_q;
    wait_cnt_d       = wait_cnt_q;
    protocol_error_d = protocol_error_q;
    timeout_d        = timeout_q;

    m_read          = 1'b0;
    m_write         = 1'b0;
    m_addr          = 32'h0;
    m_writedata     = 32'h0;
    m_byteenable    = 4'h0;
    i_waitrequest   = 1'b1;
    d_waitrequest   = 1'b1;
    i_readdatavalid = 1'b0;
    d_readdatavalid = 1'b0;
    i_readdata      = 32'h0;
    d_readdata      = 32'h0;

    case (state_q)
      S_IDLE: begin
        if (w_i_req || w_d_req) begin
          // On contention, the port that did not win last time goes first.
          if (w_i_req && w_d_req) begin
            grant_d = ~last_grant_q;
          end else begin
            grant_d = w_d_req ? C_GRANT_D : C_GRANT_I;
          end
          last_grant_d = grant_d;
          wait_cnt_d   = '0;
          state_d      = S_BUSY;
        end
      end

      S_BUSY: begin
        if (grant_q == C_GRANT_D) begin
          d_waitrequest = m_waitrequest;
        end else begin
          i_waitrequest = m_waitrequest;
        end

        if (!(w_g_read || w_g_write)) begin
          // Requester withdrew: abandon quietly.
          state_d = S_IDLE;
        end else begin
          m_read  = w_g_read;
          m_write = w_g_write;
          m_addr  = w_g_addr;
          if (grant_q == C_GRANT_D) begin
            m_writedata  = d_writedata;
            m_byteenable = d_byteenable;
          end else begin
            m_writedata  = 32'h0;
            m_byteenable = 4'hF;
          end

          if ((grant_q == C_GRANT_D) && d_read && d_write) begin
            protocol_error_d = 1'b1;
          end
          if (w_g_addr[1:0] != 2'b00) begin
            protocol_error_d = 1'b1;
          end

          if (m_waitrequest) begin
            if (wait_cnt_q == C_CNT_LAST) begin
              // Memory stalled too long: drop the access. The requester
              // still sees waitrequest and is arbitrated again from IDLE.
              timeout_d  = 1'b1;
              wait_cnt_d = '0;
              state_d    = S_IDLE;
            end else begin
              wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
          end else begin
            state_d = w_g_read ? S_RDATA : S_IDLE;
          end
        end
      end

      S_RDATA: begin
        if (grant_q == C_GRANT_D) begin
          d_readdatavalid = 1'b1;
          d_readdata      = m_readdata;
        end else begin
          i_readdatavalid = 1'b1;
          i_readdata      = m_readdata;
        end
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Reset masks the bus and the handshake outputs immediately, so an
    // access caught mid-flight is abandoned without a data pulse.
    if (reset) begin
      m_read          = 1'b0;
      m_write         = 1'b0;
      m_addr          = 32'h0;
      m_writedata     = 32'h0;
      m_byteenable    = 4'h0;
      i_waitrequest   = 1'b1;
      d_waitrequest   = 1'b1;
      i_readdatavalid = 1'b0;
      d_readdatavalid = 1'b0;
      i_readdata      = 32'h0;
      d_readdata      = 32'h0;
    end
  end

  // State, grant history, wait counter and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_IDLE;
      grant_q          <= C_GRANT_I;
      last_grant_q     <= C_GRANT_D;
      wait_cnt_q       <= '0;
      protocol_error_q <= 1'b0;
      timeout_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      grant_q          <= grant_d;
      last_grant_q     <= last_grant_d;
      wait_cnt_q       <= wait_cnt_d;
      protocol_error_q <= protocol_error_d;
      timeout_q        <= timeout_d;
    end
  end

  assign protocol_error = protocol_error_q;
  assign timeout        = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mips_cpu_bus_arbiter
// Description : Directed self-checking bench for mips_cpu_bus_arbiter with a
//               read-data scoreboard and a one-cycle-latency memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_bus_arbiter;

  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_read;
  logic [31:0] i_addr;
  logic        i_waitrequest, i_readdatavalid;
  logic [31:0] i_readdata;
  logic        d_read, d_write;
  logic [31:0] d_addr, d_writedata;
  logic [3:0]  d_byteenable;
  logic        d_waitrequest, d_readdatavalid;
  logic [31:0] d_readdata;
  logic        m_read, m_write;
  logic [31:0] m_addr, m_writedata;
  logic [3:0]  m_byteenable;
  logic        m_waitrequest;
  logic [31:0] m_readdata;
  logic        protocol_error, timeout;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        port;   // 0 = I, 1 = D
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  mips_cpu_bus_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_waitrequest(i_waitrequest),
    .i_readdatavalid(i_readdatavalid), .i_readdata(i_readdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr),
    .d_writedata(d_writedata), .d_byteenable(d_byteenable),
    .d_waitrequest(d_waitrequest), .d_readdatavalid(d_readdatavalid),
    .d_readdata(d_readdata),
    .m_read(m_read), .m_write(m_write), .m_addr(m_addr),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .protocol_error(protocol_error), .timeout(timeout)
  );

  // Memory contents as a function of address.
  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h100) return 32'h2402_0005;
    return {a[15:0], ~a[15:0]};
  endfunction

  // Memory: data for an accepted read appears on the following cycle.
  logic [31:0] mem_q = 32'h0;
  always @(posedge clk) begin
    if (m_read && !m_waitrequest) mem_q <= mem_fn(m_addr);
  end
  assign m_readdata = mem_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every readdatavalid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (i_readdatavalid || d_readdatavalid) begin
      chk("sb_single_valid", {31'h0, i_readdatavalid & d_readdatavalid}, 32'h0);
      if (sb.size() == 0) begin
        chk("sb_unexpected_valid", 32'h1, 32'h0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_port", {31'h0, d_readdatavalid}, {31'h0, e.port});
        chk("sb_data", d_readdatavalid ? d_readdata : i_readdata, e.data);
      end
    end else begin
      chk("rdata_zero_i", i_readdata, 32'h0);
      chk("rdata_zero_d", d_readdata, 32'h0);
    end
  end

  initial begin
    reset = 1'b1; i_read = 0; i_addr = 0; d_read = 0; d_write = 0;
    d_addr = 0; d_writedata = 0; d_byteenable = 0; m_waitrequest = 0;
    next(); next();

    // Reset forcing with a request present
    i_read = 1; #1;
    chk("rst_m_read", {31'h0, m_read}, 32'h0);
    chk("rst_i_wait", {31'h0, i_waitrequest}, 32'h1);
    chk("rst_d_wait", {31'h0, d_waitrequest}, 32'h1);
    chk("rst_m_be", {28'h0, m_byteenable}, 32'h0);
    chk("rst_perr", {31'h0, protocol_error}, 32'h0);
    chk("rst_tout", {31'h0, timeout}, 32'h0);
    reset = 0;

    // Contention after reset: I first, then D
    i_addr = 32'h0; d_read = 1; d_addr = 32'h400;
    sb.push_back('{1'b0, mem_fn(32'h0)});
    sb.push_back('{1'b1, mem_fn(32'h400)});
    #1;
    chk("arb_idle_m_read", {31'h0, m_read}, 32'h0);
    chk("arb_idle_i_wait", {31'h0, i_waitrequest}, 32'h1);
    next(); #1;
    chk("arb_i_m_read", {31'h0, m_read}, 32'h1);
    chk("arb_i_m_addr", m_addr, 32'h0);
    chk("arb_i_m_be", {28'h0, m_byteenable}, 32'hF);
    chk("arb_i_m_write", {31'h0, m_write}, 32'h0);
    chk("arb_i_i_wait", {31'h0, i_waitrequest}, 32'h0);
    chk("arb_i_d_wait", {31'h0, d_waitrequest}, 32'h1);
    next(); i_read = 0; #1;
    chk("arb_rdata_m_read", {31'h0, m_read}, 32'h0);
    chk("arb_rdata_d_wait", {31'h0, d_waitrequest}, 32'h1);
    next(); #1;
    chk("arb_idle2_m_read", {31'h0, m_read}, 32'h0);
    next(); #1;
    chk("arb_d_m_addr", m_addr, 32'h400);
    chk("arb_d_m_read", {31'h0, m_read}, 32'h1);
    chk("arb_d_d_wait", {31'h0, d_waitrequest}, 32'h0);
    chk("arb_d_i_wait", {31'h0, i_waitrequest}, 32'h1);
    next(); d_read = 0;
    next();

    // D write, zero wait
    d_write = 1; d_addr = 32'h404; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
    #1;
    chk("wr_idle_m_write", {31'h0, m_write}, 32'h0);
    chk("wr_idle_d_wait", {31'h0, d_waitrequest}, 32'h1);
    next(); #1;
    chk("wr_m_write", {31'h0, m_write}, 32'h1);
    chk("wr_m_be", {28'h0, m_byteenable}, 32'h3);
    chk("wr_m_wdata", m_writedata, 32'hDEAD_BEEF);
    chk("wr_m_addr", m_addr, 32'h404);
    chk("wr_d_wait", {31'h0, d_waitrequest}, 32'h0);
    next(); d_write = 0; #1;
    chk("wr_done_m_write", {31'h0, m_write}, 32'h0);
    chk("wr_done_d_wait", {31'h0, d_waitrequest}, 32'h1);
    chk("wr_perr", {31'h0, protocol_error}, 32'h0);

    // I read with three stall cycles
    i_read = 1; i_addr = 32'h100; m_waitrequest = 1;
    sb.push_back('{1'b0, 32'h2402_0005});
    next();
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("stall_i_wait", {31'h0, i_waitrequest}, 32'h1);
      chk("stall_m_read", {31'h0, m_read}, 32'h1);
      next();
    end
    m_waitrequest = 0; #1;
    chk("stall_accept_i_wait", {31'h0, i_waitrequest}, 32'h0);
    next(); i_read = 0; #1;
    chk("stall_valid", {31'h0, i_readdatavalid}, 32'h1);
    chk("stall_rdata", i_readdata, 32'h2402_0005);
    chk("stall_tout", {31'h0, timeout}, 32'h0);
    next();

    // Timeout with memory stuck busy
    i_read = 1; i_addr = 32'h200; m_waitrequest = 1;
    next();
    for (int k = 0; k < MAX_WAIT; k++) begin
      #1;
      chk("to_busy_m_read", {31'h0, m_read}, 32'h1);
      chk("to_busy_tout", {31'h0, timeout}, 32'h0);
      next();
    end
    #1;
    chk("to_abort_m_read", {31'h0, m_read}, 32'h0);
    chk("to_abort_tout", {31'h0, timeout}, 32'h1);
    chk("to_abort_i_wait", {31'h0, i_waitrequest}, 32'h1);
    next(); #1;
    chk("to_rearb_m_read", {31'h0, m_read}, 32'h1);
    chk("to_rearb_m_addr", m_addr, 32'h200);
    m_waitrequest = 0;
    sb.push_back('{1'b0, mem_fn(32'h200)});
    next(); i_read = 0;
    next();

    // D read+write together at a misaligned address
    d_read = 1; d_write = 1; d_addr = 32'h402; d_writedata = 32'h1234_5678; d_byteenable = 4'hF;
    sb.push_back('{1'b1, mem_fn(32'h402)});
    next(); #1;
    chk("pe_m_write", {31'h0, m_write}, 32'h0);
    chk("pe_m_read", {31'h0, m_read}, 32'h1);
    next(); d_read = 0; d_write = 0; #1;
    chk("pe_flag", {31'h0, protocol_error}, 32'h1);
    next();
    reset = 1;
    next(); reset = 0; #1;
    chk("pe_cleared", {31'h0, protocol_error}, 32'h0);
    chk("to_cleared", {31'h0, timeout}, 32'h0);

    // Reset while in RDATA
    i_read = 1; i_addr = 32'h300;
    next();
    next(); i_read = 0; reset = 1; #1;
    chk("rst_rdata_valid", {31'h0, i_readdatavalid}, 32'h0);
    chk("rst_rdata_m_read", {31'h0, m_read}, 32'h0);
    next(); reset = 0; #1;
    chk("rst_after_m_read", {31'h0, m_read}, 32'h0);
    chk("rst_after_valid", {31'h0, i_readdatavalid}, 32'h0);
    next(); #1;
    chk("rst_after2_valid", {31'h0, i_readdatavalid}, 32'h0);
    chk("rst_after2_m_read", {31'h0, m_read}, 32'h0);
    next(); next();

    chk("sb_drained", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
